ita_fifo_push_ctrl: RTL
=======================

Name: ita_fifo_push_ctrl

Overview:
Parametrised push controller between the requantizer array and the output FIFO.
- Delays each requantizer beat by a configurable activation latency.
- Packs the beat's N elements into one FIFO word and pushes it.
- Absorbs FIFO back-pressure in an in-order skid buffer, with credit-based stall to upstream, a sticky overflow flag, flush and a push counter.
- Generalises the fixed two-cycle, never-stalling push path.

Parameters:
- N, 16, requantized elements per beat.
- WI, 8, bits per element.
- LATENCY, 2, cycles from requant_valid_i to the beat reaching the output stage; legal range 1..4.
- SKID_DEPTH, 4, skid buffer entries; power of two, >=2.
- CNT_W, 16, width of the push counter.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset; synchronous, active-high.
- flush_i, in, 1, synchronous clear of pipeline and skid buffer.
- requant_valid_i, in, 1, requantizer beat valid (done).
- requant_oup_i, in, N*WI, N elements; element k at bits [k*WI +: WI].
- stall_o, out, 1, upstream must not assert requant_valid_i while high.
- fifo_full_i, in, 1, FIFO cannot accept a push this cycle.
- push_to_fifo_o, out, 1, push strobe.
- data_to_fifo_o, out, N*WI, packed word; element 0 in the MSBs.
- overflow_o, out, 1, sticky: a beat was dropped.
- skid_count_o, out, $clog2(SKID_DEPTH)+1, current skid occupancy.
- push_count_o, out, CNT_W, pushes since reset/flush; wraps modulo 2^CNT_W.

Behaviour:
Reset (rst_i=1 at a clock edge)
- Clears all pipeline valids, skid pointers, skid_count_o, overflow_o and push_count_o.
- Data registers are not reset.
- During and after reset: push_to_fifo_o=0, data_to_fifo_o='0, stall_o=0.

Flush (flush_i=1)
- Same clearing as reset, except overflow_o is held.
- A beat presented in the same cycle is discarded.
- rst_i has priority over flush_i.

Delay pipeline
- LATENCY register stages, each holding a valid bit and N*WI data.
- Stages always advance and never stall; the beat arrives at the output stage LATENCY cycles after its valid.
- inflight = number of valid stages.

Packing
- Packed word = element 0 at bits [N*WI-1 -: WI], element N-1 at [WI-1:0].
- Element order reversed, bits within each element unchanged.

Output stage, evaluated each cycle
- C1: skid empty, arriving beat, !fifo_full_i -> push the arriving beat directly (zero added latency).
- C2: skid non-empty, !fifo_full_i -> push the skid head and pop it. An arriving beat is written to the skid tail in the same cycle, so occupancy is unchanged.
- C3: fifo_full_i=1 -> no push. An arriving beat is written to the skid if not full; otherwise it is dropped and overflow_o is set.
- Order is strictly FIFO; a new beat never bypasses skid contents.

Push outputs
- push_to_fifo_o and data_to_fifo_o are combinational from the output-stage registers and fifo_full_i.
- data_to_fifo_o='0 whenever push_to_fifo_o=0.
- Push never asserts while fifo_full_i=1.

Stall
- stall_o = (skid_count + inflight) >= SKID_DEPTH, taken from registers only (no combinational path from fifo_full_i).
- Guarantees no overflow when upstream obeys stall_o in the same cycle.

Counter and pointers
- push_count_o increments on every push and wraps.
- Skid pointers wrap modulo SKID_DEPTH; count saturates at SKID_DEPTH only via the drop rule.

Test Plan:
1. N=16, WI=8, LATENCY=2; element k=k; one valid at cycle 0 with fifo_full_i=0 -> single push at cycle 2, data_to_fifo_o=0x000102...0E0F, push_count_o=1.
2. 8 back-to-back beats; fifo_full_i high for cycles 3..6 -> no push while full, skid_count_o peaks at 4, stall_o rises when skid+inflight=4, all 8 pushed in order, overflow_o=0.
3. Upstream ignores stall_o: 10 beats with fifo_full_i held high -> 4 stored, overflow_o=1 and stays set, then 4 pushes in order after fifo_full_i drops.
4. fifo_full_i deasserts in the same cycle a beat arrives with skid occupancy 2 -> head pushed, new beat enqueued, skid_count_o remains 2.
5. flush_i with 3 in skid and 2 in flight -> next cycle skid_count_o=0, push_count_o=0, no pushes of old data, overflow_o unchanged.
6. rst_i asserted mid-burst -> all outputs at reset values next cycle; LATENCY=1 and LATENCY=4 rerun of test 1 pushes at cycles 1 and 4.

Source files
------------

// File: rtl/ita_fifo_push_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ita_fifo_push_ctrl
//  Brief    : Delays requantizer beats by LATENCY cycles, packs them into a
//             FIFO word and pushes them, absorbing FIFO back-pressure in an
//             in-order skid buffer with credit-based upstream stall.
//  Revision : 1.0 - initial release
// ============================================================================
module ita_fifo_push_ctrl #(
  parameter int N          = 16,
  parameter int WI         = 8,
  parameter int LATENCY    = 2,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          requant_valid_i,
  input  logic [N*WI-1:0]               requant_oup_i,
  output logic                          stall_o,
  input  logic                          fifo_full_i,
  output logic                          push_to_fifo_o,
  output logic [N*WI-1:0]               data_to_fifo_o,
  output logic                          overflow_o,
  output logic [$clog2(SKID_DEPTH):0]   skid_count_o,
  output logic [CNT_W-1:0]              push_count_o
);

  localparam int W     = N * WI;
  localparam int PW    = $clog2(SKID_DEPTH);
  localparam int SCW   = PW + 1;
  localparam int SUM_W = SCW + 4;

  // Element 0 goes to the MSBs; bit order inside each element is kept.
  logic [W-1:0] packed_in;
  generate
    for (genvar k = 0; k < N; k++) begin : g_pack
      assign packed_in[(N-1-k)*WI +: WI] = requant_oup_i[k*WI +: WI];
    end
  endgenerate

  logic [LATENCY-1:0] pipe_valid;
  logic [W-1:0]       pipe_data [LATENCY];

  // Delay line valid bits: free-running shift, cleared by reset or flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= requant_valid_i;
      for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // Delay line data: not reset, qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    pipe_data[0] <= packed_in;
    for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  logic         arrive_valid;
  logic [W-1:0] arrive_data;
  assign arrive_valid = pipe_valid[LATENCY-1];
  assign arrive_data  = pipe_data[LATENCY-1];

  logic [W-1:0]     skid_mem [SKID_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [SCW-1:0]   skid_count;
  logic             overflow;
  logic [CNT_W-1:0] push_count;

  logic skid_empty, skid_full, active, push, pop, direct, enq, drop;

  // Output-stage decision: direct push, push from skid head, or hold/drop.
  always_comb begin
    skid_empty = (skid_count == '0);
    skid_full  = (skid_count == SCW'(SKID_DEPTH));
    active     = !rst_i && !flush_i;
    push       = active && !fifo_full_i && (!skid_empty || arrive_valid);
    pop        = push && !skid_empty;
    direct     = push && skid_empty;
    enq        = active && arrive_valid && !direct && (pop || !skid_full);
    drop       = active && arrive_valid && !direct && !pop && skid_full;
    data_to_fifo_o = '0;
    if (push) data_to_fifo_o = skid_empty ? arrive_data : skid_mem[rd_ptr];
  end

  assign push_to_fifo_o = push;

  logic [SUM_W-1:0] inflight;

  // Credit check from registered state only: beats in flight plus stored.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + {{(SUM_W-1){1'b0}}, pipe_valid[i]};
    stall_o = !rst_i &&
              (({{(SUM_W-SCW){1'b0}}, skid_count} + inflight) >= SUM_W'(SKID_DEPTH));
  end

  // Skid pointers, occupancy, sticky overflow and push counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      skid_count <= '0;
      overflow   <= 1'b0;
      push_count <= '0;
    end else if (flush_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      skid_count <= '0;
      push_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   skid_count <= skid_count + 1'b1;
        2'b01:   skid_count <= skid_count - 1'b1;
        default: skid_count <= skid_count;
      endcase
      if (drop) overflow <= 1'b1;
      if (push) push_count <= push_count + 1'b1;
    end
  end

  // Skid storage: written at the tail, not reset.
  always_ff @(posedge clk_i) begin
    if (enq) skid_mem[wr_ptr] <= arrive_data;
  end

  assign overflow_o   = overflow;
  assign skid_count_o = skid_count;
  assign push_count_o = push_count;

endmodule
`default_nettype wire
